// File: rtl/msfsms_fire_scheduler_pkg.sv
// Shared constants for the Petri-net fire scheduler: net size, conflict
// group count, default group membership and transition indices.
package msfsms_fire_scheduler_pkg;

    localparam int NT = 7;
    localparam int NG = 5;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;

    // Row g is the member mask of conflict group g; each transition belongs
    // to exactly one group.
    // Groups: {t0,t1}, {t2}, {t3,t4}, {t5}, {t6}
    localparam logic [NG-1:0][NT-1:0] GROUP_MAP_DEFAULT = {
        7'b1000000,
        7'b0100000,
        7'b0011000,
        7'b0000100,
        7'b0000011
    };

endpackage

// File: rtl/msfsms_fire_scheduler_rr_arbiter.sv
// Round-robin arbiter for one conflict group.
// Ports:
//   req_mask   - candidate transitions (full NT width)
//   group_mask - members of this group
//   ptr        - index where the ascending search starts
//   grant      - one-hot grant (zero when no member is a candidate)
//   next_ptr   - one past the granted index, or ptr when nothing granted
module msfsms_rr_arbiter #(
    parameter int NT = 7,
    parameter int PW = 3
) (
    input  logic [NT-1:0] req_mask,
    input  logic [NT-1:0] group_mask,
    input  logic [PW-1:0] ptr,
    output logic [NT-1:0] grant,
    output logic [PW-1:0] next_ptr
);
    import msfsms_fire_scheduler_pkg::*;

    int          idx_i;
    logic [PW-1:0] idx;
    logic        found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx_i    = 0;
        idx      = '0;
        for (int off = 0; off < NT; off++) begin
            idx_i = (int'(ptr) + off) % NT;
            idx   = PW'(idx_i);
            if (!found && req_mask[idx] && group_mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                next_ptr   = PW'((idx_i + 1) % NT);
            end
        end
    end

endmodule

// File: rtl/msfsms_fire_scheduler.sv
// Fire scheduler for a Mealy FSM array modelling a Petri net. Each cycle it
// picks at most one enabled, requested transition per conflict group
// (round-robin within the group) and presents the winners on fire one cycle
// later as single-cycle pulses.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   req        - level request per transition
//   en         - enabling mask per transition
//   halt       - suppress all grants while high
//   fire       - registered one-cycle firing pulses
//   conflict   - registered: a group had 2+ candidates at the decision
//   fire_cnt   - running count of fired transitions, wraps at 2^16
module msfsms_fire_scheduler #(
    parameter int NT = msfsms_fire_scheduler_pkg::NT,
    parameter int NG = msfsms_fire_scheduler_pkg::NG,
    parameter logic [NG-1:0][NT-1:0] GROUP_MAP = msfsms_fire_scheduler_pkg::GROUP_MAP_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NT-1:0] req,
    input  logic [NT-1:0] en,
    input  logic          halt,
    output logic [NT-1:0] fire,
    output logic          conflict,
    output logic [15:0]   fire_cnt
);
    import msfsms_fire_scheduler_pkg::*;

    localparam int PW = (NT > 1) ? $clog2(NT) : 1;

    logic [NG-1:0][PW-1:0] ptr;
    logic [NG-1:0][PW-1:0] next_ptr;
    logic [NG-1:0][NT-1:0] grant;
    logic [NG-1:0]         holdoff;
    logic [NG-1:0]         granted;
    logic [NG-1:0]         multi;
    logic [NT-1:0]         holdoff_mask;
    logic [NT-1:0]         cand;
    logic [NT-1:0]         grant_all;

    function automatic logic [PW-1:0] lowest_member(input logic [NT-1:0] m);
        lowest_member = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (m[i]) lowest_member = PW'(i);
        end
    endfunction

    // A group that is firing right now sees stale en from its FSMs, so it
    // sits out this decision.
    always_comb begin
        holdoff_mask = '0;
        for (int g = 0; g < NG; g++) begin
            if (holdoff[g]) holdoff_mask = holdoff_mask | GROUP_MAP[g];
        end
    end

    assign cand = req & en & ~{NT{halt}} & ~holdoff_mask;

    for (genvar g = 0; g < NG; g++) begin : gen_grp
        msfsms_rr_arbiter #(
            .NT (NT),
            .PW (PW)
        ) u_arb (
            .req_mask   (cand),
            .group_mask (GROUP_MAP[g]),
            .ptr        (ptr[g]),
            .grant      (grant[g]),
            .next_ptr   (next_ptr[g])
        );
        assign granted[g] = |grant[g];
        assign multi[g]   = ($countones(cand & GROUP_MAP[g]) > 1);
    end

    always_comb begin
        grant_all = '0;
        for (int g = 0; g < NG; g++) begin
            grant_all = grant_all | grant[g];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < NG; g++) begin
                ptr[g] <= lowest_member(GROUP_MAP[g]);
            end
            holdoff  <= '0;
            fire     <= '0;
            conflict <= 1'b0;
            fire_cnt <= '0;
        end else begin
            // next_ptr equals ptr for a group with no grant (incl. halt).
            ptr      <= next_ptr;
            holdoff  <= granted;
            fire     <= grant_all;
            conflict <= |multi;
            fire_cnt <= fire_cnt + 16'($countones(fire));
        end
    end

endmodule

// File: tb/tb_msfsms_fire_scheduler.sv
module tb_msfsms_fire_scheduler;

    logic        clk;
    logic        reset;
    logic [6:0]  req;
    logic [6:0]  en;
    logic        halt;
    logic [6:0]  fire;
    logic        conflict;
    logic [15:0] fire_cnt;

    int tests;
    int fails;

    msfsms_fire_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .en       (en),
        .halt     (halt),
        .fire     (fire),
        .conflict (conflict),
        .fire_cnt (fire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        en    = '0;
        halt  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (fire !== 7'b0 || conflict !== 1'b0 || fire_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: fire=%b conflict=%b cnt=%0d, want 0/0/0", fire, conflict, fire_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 7'b0000100;
        en  = 7'b0000100;
        @(negedge clk);
        tests++;
        if (fire !== 7'b0000100 || conflict !== 1'b0) begin
            fails++;
            $display("FAIL single_fire: fire=%b conflict=%b, want 0000100/0", fire, conflict);
        end
        req = '0;
        @(negedge clk);
        tests++;
        if (fire !== 7'b0 || fire_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_after: fire=%b cnt=%0d, want 0000000/1", fire, fire_cnt);
        end
    endtask

    task automatic test_conflict();
        logic [6:0] exp_f [4];
        logic       exp_c [4];
        exp_f = '{7'b0000001, 7'b0000000, 7'b0000010, 7'b0000000};
        exp_c = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        req = 7'b0000011;
        en  = 7'b0000011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (fire !== exp_f[i] || conflict !== exp_c[i]) begin
                fails++;
                $display("FAIL conflict_seq[%0d]: fire=%b conflict=%b, want %b/%b", i, fire, conflict, exp_f[i], exp_c[i]);
            end
        end
        req = '0;
        @(negedge clk);
        tests++;
        if (fire_cnt !== 16'd2) begin
            fails++;
            $display("FAIL conflict_cnt: cnt=%0d, want 2", fire_cnt);
        end
    endtask

    task automatic test_concurrency();
        do_reset();
        req = 7'b1000101;
        en  = 7'b1000101;
        @(negedge clk);
        tests++;
        if (fire !== 7'b1000101 || conflict !== 1'b0) begin
            fails++;
            $display("FAIL concurrency: fire=%b conflict=%b, want 1000101/0", fire, conflict);
        end
        req = '0;
        @(negedge clk);
        tests++;
        if (fire_cnt !== 16'd3) begin
            fails++;
            $display("FAIL concurrency_cnt: cnt=%0d, want 3", fire_cnt);
        end
    endtask

    task automatic test_en_no_req();
        do_reset();
        en = 7'b1111111;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (fire !== 7'b0 || fire_cnt !== 16'd0) begin
            fails++;
            $display("FAIL en_no_req: fire=%b cnt=%0d, want 0/0", fire, fire_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1'b1;
        req  = 7'b0001000;
        en   = 7'b0001000;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (fire !== 7'b0) begin
            fails++;
            $display("FAIL halt_block: fire=%b, want 0000000", fire);
        end
        halt = 1'b0;
        @(negedge clk);
        tests++;
        if (fire !== 7'b0001000) begin
            fails++;
            $display("FAIL halt_release: fire=%b, want 0001000", fire);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_stale_en();
        do_reset();
        halt = 1'b1;
        req  = 7'b0001000;
        en   = 7'b0001000;
        @(negedge clk);
        halt = 1'b0;
        en   = 7'b0000000;
        @(negedge clk);
        tests++;
        if (fire !== 7'b0) begin
            fails++;
            $display("FAIL stale_en_1: fire=%b, want 0000000", fire);
        end
        @(negedge clk);
        tests++;
        if (fire !== 7'b0 || fire_cnt !== 16'd0) begin
            fails++;
            $display("FAIL stale_en_2: fire=%b cnt=%0d, want 0/0", fire, fire_cnt);
        end
        req = '0;
    endtask

    task automatic test_wrap();
        int bits;
        int cycles;
        bits   = 0;
        cycles = 0;
        do_reset();
        // five groups fire together every other cycle: 13107 rounds x 5 = 65535
        req = 7'b1111111;
        en  = 7'b1111111;
        while (bits < 65535 && cycles < 40000) begin
            @(negedge clk);
            cycles++;
            bits += $countones(fire);
        end
        req = '0;
        tests++;
        if (bits !== 65535) begin
            fails++;
            $display("FAIL wrap_preload_bits: observed %0d fired bits in %0d cycles, want 65535", bits, cycles);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (fire_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload_cnt: cnt=%0d, want 65535", fire_cnt);
        end
        req = 7'b0000100;
        en  = 7'b0000100;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        tests++;
        if (fire_cnt !== 16'd0) begin
            fails++;
            $display("FAIL wrap_cnt: cnt=%0d, want 0", fire_cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        req = 7'b0100000;
        en  = 7'b0100000;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        req = 7'b0100000;
        @(negedge clk);
        tests++;
        if (fire !== 7'b0100000 || fire_cnt !== 16'd1) begin
            fails++;
            $display("FAIL mid_pulse_setup: fire=%b cnt=%0d, want 0100000/1", fire, fire_cnt);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (fire !== 7'b0 || conflict !== 1'b0 || fire_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_pulse_reset: fire=%b conflict=%b cnt=%0d, want 0/0/0", fire, conflict, fire_cnt);
        end
        req = '0;
        en  = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        req   = '0;
        en    = '0;
        halt  = 1'b0;
        test_reset();
        test_single();
        test_conflict();
        test_concurrency();
        test_en_no_req();
        test_halt();
        test_stale_en();
        test_wrap();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msfsms_fire_scheduler.md
MSFSMS_FIRE_SCHEDULER -- requirements
Module: msfsms_fire_scheduler

Interface
REQ-001 SHALL have parameter NT, default 7, number of net transitions t0..t(NT-1).
REQ-002 SHALL have parameter NG, default 5, number of conflict groups.
REQ-003 SHALL have parameter GROUP_MAP, default from package, NG x NT one-hot-per-transition mask. Default groups: {t0,t1}, {t2}, {t3,t4}, {t5}, {t6}.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NT  level request per transition from environment.
REQ-007 en  input  NT  enabling mask per transition, decoded from the state-sync outputs of the Mealy FSMs.
REQ-008 halt  input  1  when high, no firing is issued.
REQ-009 fire  output  NT  registered one-cycle firing pulses; drives t0..t(NT-1) of the Mealy FSM array.
REQ-010 conflict  output  1  registered pulse: some group had more than one candidate this decision.
REQ-011 fire_cnt  output  16  total number of transitions fired.

Function
REQ-012 A transition is a candidate when req[i] & en[i] & ~halt are all true and its group is not in holdoff.
REQ-013 Each group SHALL grant at most one candidate per cycle, chosen by round-robin.
REQ-014 Within a group, the round-robin pointer SHALL advance to one past the granted index. Search order is ascending with wrap-around.
REQ-015 Distinct groups SHALL grant concurrently; fire may have several bits set, one at most per group.
REQ-016 The grant decided in cycle k SHALL appear on fire in cycle k+1 (latency 1), and fire SHALL deassert after one cycle.
REQ-017 Holdoff: a group that fired in cycle k+1 SHALL NOT be granted in the decision made during cycle k+1. This covers the one cycle in which en is stale.
REQ-018 Consequence of REQ-017: the same group never fires on consecutive cycles.
REQ-019 req is level-sensitive. The requester SHALL drop req once it sees fire[i]. If req is still high after holdoff, it is a new request.
REQ-020 When halt is high, fire SHALL be 0 next cycle, pointers SHALL hold, and holdoff SHALL still expire.
REQ-021 conflict SHALL be 1 in the cycle fire is presented if any group had two or more candidates at the decision; otherwise 0.
REQ-022 fire_cnt SHALL add popcount(fire) each cycle, modulo 2^16, wrapping from 16'hFFFF.
REQ-023 A candidate whose en drops before the decision SHALL NOT be granted; no request is queued.
REQ-024 If en rises without a matching req, no action SHALL be taken.

Reset
REQ-025 While reset is high, fire = 0, conflict = 0, fire_cnt = 0, all pointers = lowest member of each group, and all holdoff flags clear. All are asynchronous.
REQ-026 If reset asserts mid-pulse, fire SHALL clear immediately.
REQ-027 The first decision SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold: NT, NG, the default GROUP_MAP constant, and the transition index constants T0..T6.
REQ-029 One sub-module, msfsms_rr_arbiter (NT-wide request mask, group mask, pointer; outputs one-hot grant and next pointer), SHALL be instantiated once per group via generate.
REQ-030 Counter, holdoff and output registers SHALL live in the top module.

Verification
REQ-031 Single request: after reset, req=7'b0000100, en=7'b0000100 -> fire=7'b0000100 for exactly one cycle, one cycle later; fire_cnt=1; conflict=0.
REQ-032 Free-choice conflict: req=en=7'b0000011 held for 4 cycles -> fire = t0, idle, t1, idle. Each fire has conflict=1; fire_cnt=2.
REQ-033 Concurrency: req=en=7'b1000101 -> fire=7'b1000101 in one cycle; fire_cnt=3.
REQ-034 Halt and stale enabling:
- Halt: assert halt during a pending req=en=7'b0001000 -> no fire; release halt -> fire=7'b0001000 one cycle later.
- Stale en: drop en[3] in the same cycle halt releases -> no fire.
REQ-035 Wrap and reset:
- Wrap: preload by firing 65535 times, then one more -> fire_cnt=0.
- Reset: assert reset while fire=7'b0100000 -> fire=0 without a clock edge, and all outputs are 0.
